tx_serializer_10b: RTL and testbench
====================================

Name: tx_serializer_10b

Overview:
Downstream neighbour of the 8b10b encoder in the SerDes TX path. It accepts 10-bit encoded code-groups (TxParallel_10) through a valid/ready handshake into a one-word holding register, then shifts each word out serially, one bit per BitCLK cycle. When no word is available at a word boundary, it inserts a programmable idle code-group (K28.5, RD-) so the serial line never stalls.

Parameters:
WORD_W, 10, code-group width; fixed at 10 and used only for readability.
IDLE_WORD, 10'h17C, word inserted on underflow (K28.5 RD-, bit0 = 'a').
MSB_FIRST, 0, 0: bit 0 is transmitted first; 1: bit 9 is transmitted first.

Ports:
BitCLK  input  1  serial bit clock; every flop samples on the rising edge.
Reset  input  1  asynchronous, active-high reset.
TxParallel_10  input  10  encoded code-group from the encoder.
TxValid_10  input  1  TxParallel_10 is valid this cycle.
TxReady_10  output  1  block can accept a word this cycle.
TxSerial  output  1  serial bit stream, driven directly from a flop.
WordStart  output  1  high in the bit-time that carries the first bit of a word.
IdleInsert  output  1  high for all 10 bit-times of an inserted IDLE_WORD.

Behaviour:
- State:
  - bit_cnt: 0..9.
  - sh[9:0]: shift register.
  - hold[9:0] with hold_valid.
- Reset values (asynchronous):
  - bit_cnt = 9, sh = 0, hold_valid = 0.
  - TxSerial = 0, WordStart = 0, IdleInsert = 0, TxReady_10 = 0.
- TxReady_10 = !hold_valid && !Reset. It is combinational from flops, with no combinational path from TxValid_10.
- Accept: a word is taken on a rising edge where TxValid_10 && TxReady_10 are both high.
- Load cycle: any edge where bit_cnt == 9. On that edge, bit_cnt becomes 0 and sh loads by priority:
  1. hold_valid = 1: sh <= hold; hold_valid <= 0.
  2. Else, if a word is accepted this same edge: sh <= TxParallel_10 directly (bypass); hold_valid stays 0.
  3. Else: sh <= IDLE_WORD; IdleInsert <= 1 for the next 10 bit-times.
- In case 1, TxReady_10 was 0 during that cycle, so no accept can collide with the load.
- Non-load edge:
  - bit_cnt increments.
  - sh shifts toward the output: right when MSB_FIRST = 0, left when MSB_FIRST = 1.
  - An accepted word is written into hold, and hold_valid <= 1.
- TxSerial is the output bit of sh: sh[0] when MSB_FIRST = 0, sh[9] when MSB_FIRST = 1.
- WordStart = (bit_cnt == 0), registered; high exactly 1 of every 10 cycles.
- IdleInsert is registered. It is set at a case-3 load and cleared at the next load that takes a real word.
- The first edge after Reset deasserts is a load cycle, so the first word is an idle unless a word is accepted in that cycle (bypass).
- Latency:
  - Bypassed word: bit 0 appears on TxSerial in the cycle after the accept edge.
  - Held word: bit 0 appears in the cycle after the next load edge.
  - The worst case is 10 cycles from accept to first bit.
- Throughput: one word per 10 cycles. Upstream that asserts TxValid_10 continuously sees no idle insertion after the first word.
- Reset asserted mid-word: the word in flight and the held word are discarded. TxSerial goes to 0 immediately, with no partial word completed.
- TxParallel_10 is not checked for code validity; running-disparity correctness is owned by the encoder.

Test Plan:
- Reset release with TxValid_10 = 0 for 30 cycles -> TxSerial repeats 0,0,1,1,1,1,1,0,1,0 three times; IdleInsert = 1 throughout; WordStart pulses at cycles 1, 11, 21.
- Single word 10'h2A5 accepted in the cycle after reset release (bypass) -> TxSerial = 1,0,1,0,0,1,0,1,0,1 on the next 10 cycles; IdleInsert = 0; then IDLE_WORD.
- Continuous stream 10'h155, 10'h2AA, 10'h0F3 with TxValid_10 held high -> back-to-back words with no idle between them; TxReady_10 low 9 of every 10 cycles once hold is full.
- Word offered at bit_cnt = 4 while hold is empty -> accepted into hold; its bit 0 appears exactly 6 cycles later; no underflow.
- Reset asserted at bit_cnt = 5 of word 10'h3FF -> TxSerial = 0 and TxReady_10 = 0 asynchronously; after release, an idle word is sent, with no remaining 1s from 10'h3FF.
- MSB_FIRST = 1 with word 10'h200 -> TxSerial = 1 then nine 0s.

Source files
------------

// File: rtl/tx_serializer_10b_if.sv
// Parallel handshake and serial line of the 10b TX serializer.
// The encoder side is the master; the serializer is the slave.
interface tx_serializer_10b_if #(
   parameter int unsigned WORD_W = 10
);
   logic [WORD_W-1:0] TxParallel_10;
   logic              TxValid_10;
   logic              TxReady_10;
   logic              TxSerial;
   logic              WordStart;
   logic              IdleInsert;

   modport master (
      output TxParallel_10,
      output TxValid_10,
      input  TxReady_10,
      input  TxSerial,
      input  WordStart,
      input  IdleInsert
   );

   modport slave (
      input  TxParallel_10,
      input  TxValid_10,
      output TxReady_10,
      output TxSerial,
      output WordStart,
      output IdleInsert
   );
endinterface

// File: rtl/tx_serializer_10b.sv
// 10-bit code-group serializer: one-word holding register in front of a
// shift register, one bit per BitCLK. Underflow at a word boundary sends
// IDLE_WORD so the line never stalls.
module tx_serializer_10b #(
   parameter int unsigned       WORD_W    = 10,
   parameter logic [WORD_W-1:0] IDLE_WORD = 10'h17C,
   parameter bit                MSB_FIRST = 1'b0
) (
   input logic                BitCLK,
   input logic                Reset,
   tx_serializer_10b_if.slave tx_if
);

   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic              word_start_q, word_start_d;
   logic              idle_q, idle_d;
   logic              load;
   logic              accept;

   // Ready depends only on flops and Reset, never on TxValid_10.
   assign tx_if.TxReady_10 = !hold_valid_q && !Reset;
   assign accept           = tx_if.TxValid_10 && tx_if.TxReady_10;
   assign load             = (bit_cnt_q == 4'd9);

   // Next state: load a word at the boundary, otherwise shift and capture into hold.
   always_comb begin
      bit_cnt_d    = bit_cnt_q + 4'd1;
      sh_d         = MSB_FIRST ? {sh_q[WORD_W-2:0], 1'b0} : {1'b0, sh_q[WORD_W-1:1]};
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      idle_d       = idle_q;
      word_start_d = 1'b0;
      if (load) begin
         bit_cnt_d    = 4'd0;
         word_start_d = 1'b1;
         if (hold_valid_q) begin
            sh_d         = hold_q;
            hold_valid_d = 1'b0;
            idle_d       = 1'b0;
         end else if (accept) begin
            // Bypass: hold is empty and the word goes straight to the shifter.
            sh_d   = tx_if.TxParallel_10;
            idle_d = 1'b0;
         end else begin
            sh_d   = IDLE_WORD;
            idle_d = 1'b1;
         end
      end else if (accept) begin
         hold_d       = tx_if.TxParallel_10;
         hold_valid_d = 1'b1;
      end
   end

   // State registers; reset discards both the word in flight and the held word.
   always_ff @(posedge BitCLK or posedge Reset) begin
      if (Reset) begin
         bit_cnt_q    <= 4'd9;
         sh_q         <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         word_start_q <= 1'b0;
         idle_q       <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         sh_q         <= sh_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         word_start_q <= word_start_d;
         idle_q       <= idle_d;
      end
   end

   assign tx_if.TxSerial   = MSB_FIRST ? sh_q[WORD_W-1] : sh_q[0];
   assign tx_if.WordStart  = word_start_q;
   assign tx_if.IdleInsert = idle_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Bench for tx_serializer_10b: LSB-first and MSB-first instances share stimulus;
// a queue-based line model feeds a scoreboard checked every bit-time.
module tb_tx_serializer_10b;

   localparam logic [9:0] IDLE = 10'h17C;

   typedef struct packed {
      logic       idl;
      logic [3:0] pos;
      logic [9:0] w;
   } exp_t;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       tb_valid = 1'b0;
   logic [9:0] tb_data  = '0;

   exp_t       exp_q[$];
   logic [9:0] pend_q[$];
   int         k        = 0;
   bit         acc_flag = 1'b0;
   int         n_chk    = 0;
   int         n_err    = 0;

   always #5 clk = ~clk;

   tx_serializer_10b_if if_lsb ();
   tx_serializer_10b_if if_msb ();

   assign if_lsb.TxParallel_10 = tb_data;
   assign if_lsb.TxValid_10    = tb_valid;
   assign if_msb.TxParallel_10 = tb_data;
   assign if_msb.TxValid_10    = tb_valid;

   tx_serializer_10b #(.MSB_FIRST(1'b0)) u_lsb (
      .BitCLK (clk),
      .Reset  (rst),
      .tx_if  (if_lsb.slave)
   );

   tx_serializer_10b #(.MSB_FIRST(1'b1)) u_msb (
      .BitCLK (clk),
      .Reset  (rst),
      .tx_if  (if_msb.slave)
   );

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
      end
   endtask

   // Line model: words start every 10 edges after reset; a word waits in a
   // one-deep pending slot, else an accepted word goes out directly, else idle.
   logic [9:0] m_w;
   logic       m_idl;
   bit         m_acc;
   always @(posedge clk) begin
      if (!rst) begin
         m_acc    = tb_valid && (pend_q.size() == 0);
         acc_flag = m_acc;
         if (k % 10 == 0) begin
            if (pend_q.size() > 0) begin
               m_w   = pend_q.pop_front();
               m_idl = 1'b0;
            end else if (m_acc) begin
               m_w   = tb_data;
               m_idl = 1'b0;
            end else begin
               m_w   = IDLE;
               m_idl = 1'b1;
            end
            for (int i = 0; i < 10; i++) exp_q.push_back({m_idl, 4'(i), m_w});
         end else if (m_acc) begin
            pend_q.push_back(tb_data);
         end
         k++;
      end else begin
         acc_flag = 1'b0;
      end
   end

   // Scoreboard monitor, sampled mid-cycle.
   exp_t       e;
   logic [9:0] mw;
   int         p;
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_serial_lsb", 10'(if_lsb.TxSerial), 10'd0);
         chk("rst_serial_msb", 10'(if_msb.TxSerial), 10'd0);
         chk("rst_ready", 10'(if_lsb.TxReady_10), 10'd0);
         chk("rst_wordstart", 10'(if_lsb.WordStart), 10'd0);
         chk("rst_idle", 10'(if_lsb.IdleInsert), 10'd0);
      end else begin
         chk("ready_lsb", 10'(if_lsb.TxReady_10), 10'(pend_q.size() == 0));
         chk("ready_msb", 10'(if_msb.TxReady_10), 10'(pend_q.size() == 0));
         if (exp_q.size() == 0) begin
            chk("pre_load_serial", 10'(if_lsb.TxSerial), 10'd0);
            chk("pre_load_wordstart", 10'(if_lsb.WordStart), 10'd0);
            chk("pre_load_idle", 10'(if_lsb.IdleInsert), 10'd0);
         end else begin
            e  = exp_q.pop_front();
            mw = e.w;
            p  = int'(e.pos);
            chk("serial_lsb", 10'(if_lsb.TxSerial), 10'(mw[p]));
            chk("serial_msb", 10'(if_msb.TxSerial), 10'(mw[9-p]));
            chk("wordstart_lsb", 10'(if_lsb.WordStart), 10'(p == 0));
            chk("wordstart_msb", 10'(if_msb.WordStart), 10'(p == 0));
            chk("idle_lsb", 10'(if_lsb.IdleInsert), 10'(e.idl));
            chk("idle_msb", 10'(if_msb.IdleInsert), 10'(e.idl));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      tb_valid = 1'b0;
      pend_q.delete();
      exp_q.delete();
      k = 0;
      #1;
      chk("async_rst_serial_lsb", 10'(if_lsb.TxSerial), 10'd0);
      chk("async_rst_serial_msb", 10'(if_msb.TxSerial), 10'd0);
      chk("async_rst_ready", 10'(if_lsb.TxReady_10), 10'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send(input logic [9:0] w, input bit last);
      bit done;
      done     = 1'b0;
      tb_data  = w;
      tb_valid = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(posedge clk);
         #1;
         if (acc_flag) done = 1'b1;
      end
      n_chk++;
      if (!done) begin
         n_err++;
         $display("FAIL accept_timeout: word %h not accepted within 30 cycles", w);
      end
      if (last) tb_valid = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < 20 && (k % 10 != ph); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Idle stream after reset.
      do_reset();
      repeat (30) @(posedge clk);
      // Bypass on the first load edge.
      do_reset();
      send(10'h2A5, 1'b1);
      repeat (20) @(posedge clk);
      // Continuous stream, valid held high.
      send(10'h155, 1'b0);
      send(10'h2AA, 1'b0);
      send(10'h0F3, 1'b1);
      repeat (25) @(posedge clk);
      // Offer mid-word into an empty hold.
      wait_phase(5);
      send(10'h1C7, 1'b1);
      repeat (15) @(posedge clk);
      // Single high bit shows bit ordering on both instances.
      send(10'h200, 1'b1);
      repeat (15) @(posedge clk);
      // Reset in the middle of an all-ones word.
      do_reset();
      send(10'h3FF, 1'b1);
      repeat (5) @(posedge clk);
      do_reset();
      repeat (25) @(posedge clk);
      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         tb_valid = 1'($urandom_range(0, 1));
         tb_data  = 10'($urandom);
      end
      tb_valid = 1'b0;
      repeat (20) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
